// File: rtl/mmio_io_responder_pkg.sv
// Shared constants for the MMIO IO responder: window base, register offsets
// and the active-low 7-segment glyph table.
package mmio_io_responder_pkg;

  localparam logic [31:0] IO_BASE = 32'hFFFFF800;

  localparam logic [9:0] OFF_LED    = 10'h000;
  localparam logic [9:0] OFF_SW     = 10'h004;
  localparam logic [9:0] OFF_KEY    = 10'h008;
  localparam logic [9:0] OFF_SEG    = 10'h00C;
  localparam logic [9:0] OFF_TICK   = 10'h010;
  localparam logic [9:0] OFF_SEGCTL = 10'h014;

  // Bit 0 = segment a ... bit 6 = g, bit 7 = dp; all active-low, dp held off.
  localparam logic [7:0] SEG_LUT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
    return SEG_LUT[nib];
  endfunction

endpackage

// File: rtl/mmio_io_responder_seg7_scan.sv
// Time-multiplexed 8-digit 7-segment driver: slot timer, digit index and
// registered anode/cathode outputs.
module seg7_scan
  import mmio_io_responder_pkg::*;
#(
  parameter int SCAN_DIV = 100_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] seg_val,
  input  logic [8:0]  seg_ctrl,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cath
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LOAD = SLOT_W'(SCAN_DIV - 1);

  logic [SLOT_W-1:0] slot_cnt;
  logic [2:0]        digit_idx;
  logic [7:0]        mask;

  assign mask = seg_ctrl[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt  <= SLOT_LOAD;
      digit_idx <= 3'd0;
      seg_an    <= 8'hFF;
      seg_cath  <= 8'hFF;
    end else begin
      if (slot_cnt == '0) begin
        slot_cnt  <= SLOT_LOAD;
        digit_idx <= digit_idx + 3'd1;
      end else begin
        slot_cnt <= slot_cnt - 1'b1;
      end
      seg_an   <= (seg_ctrl[8] && mask[digit_idx]) ? ~(8'b1 << digit_idx) : 8'hFF;
      seg_cath <= hex_glyph(seg_val[{digit_idx, 2'b00} +: 4]);
    end
  end

endmodule

// File: rtl/mmio_io_responder.sv
// Memory-mapped IO slave: LED/switch/key/7-seg/ms-tick registers with registered reads.
// Optional key debouncing is built when KEY_DEBOUNCE_EN is defined.
module mmio_io_responder
  import mmio_io_responder_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int SCAN_DIV    = 100_000,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_read,
  input  logic        io_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  input  logic [15:0] switches,
  input  logic [4:0]  keys,
  output logic [15:0] leds,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cath
);

  localparam logic [31:0] PRESC_MAX = 32'(CLK_HZ / 1000 - 1);

  logic [9:0]  off;
  logic [15:0] sw_s1, sw_s2;
  logic [4:0]  key_s1, key_s2, key_lvl, key_d, key_edge, key_stat;
  logic [31:0] seg_val;
  logic [8:0]  seg_ctrl;
  logic [31:0] presc, tick_cnt;
  logic        ms_tick;
  logic [31:0] rd_mux;
  logic        unused;

  assign off     = {addr[9:2], 2'b00};
  assign ms_tick = (presc == PRESC_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      key_s1 <= '0;
      key_s2 <= '0;
    end else begin
      sw_s1  <= switches;
      sw_s2  <= sw_s1;
      key_s1 <= keys;
      key_s2 <= key_s1;
    end
  end

`ifdef KEY_DEBOUNCE_EN
  localparam int DB_LOAD_I = (DEBOUNCE_MS > 1) ? DEBOUNCE_MS : 1;
  localparam int DB_W      = $clog2(DB_LOAD_I + 1);
  localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DB_LOAD_I);

  logic [4:0]      key_stable;
  logic [DB_W-1:0] db_cnt [5];

  // Each disagreeing key counts down ms ticks; any agreement restarts the hold window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_stable <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= DB_LOAD;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (key_s2[i] == key_stable[i]) begin
          db_cnt[i] <= DB_LOAD;
        end else if (ms_tick) begin
          if (db_cnt[i] == DB_W'(1)) begin
            key_stable[i] <= key_s2[i];
            db_cnt[i]     <= DB_LOAD;
          end else begin
            db_cnt[i] <= db_cnt[i] - 1'b1;
          end
        end
      end
    end
  end

  assign key_lvl = key_stable;
  assign unused  = ^{addr[31:10], addr[1:0]};
`else
  assign key_lvl = key_s2;
  assign unused  = ^{addr[31:10], addr[1:0], 32'(DEBOUNCE_MS)};
`endif

  assign key_edge = key_lvl & ~key_d;

  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_LED:    rd_mux = {16'h0000, leds};
      OFF_SW:     rd_mux = {16'h0000, sw_s2};
      OFF_KEY:    rd_mux = {27'd0, key_stat};
      OFF_SEG:    rd_mux = seg_val;
      OFF_TICK:   rd_mux = tick_cnt;
      OFF_SEGCTL: rd_mux = {23'd0, seg_ctrl};
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds        <= '0;
      seg_val     <= '0;
      seg_ctrl    <= 9'h1FF;
      key_d       <= '0;
      key_stat    <= '0;
      presc       <= '0;
      tick_cnt    <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      if (io_write) begin
        case (off)
          OFF_LED:    leds     <= wdata[15:0];
          OFF_SEG:    seg_val  <= wdata;
          OFF_SEGCTL: seg_ctrl <= wdata[8:0];
          default:    ;
        endcase
      end
      key_d <= key_lvl;
      // A fresh edge in the read cycle survives the clear.
      key_stat <= (key_stat & ~{5{io_read && (off == OFF_KEY)}}) | key_edge;
      if (ms_tick) begin
        presc    <= '0;
        tick_cnt <= tick_cnt + 32'd1;
      end else begin
        presc <= presc + 32'd1;
      end
      rdata_valid <= io_read;
      if (io_read) rdata <= rd_mux;
    end
  end

  seg7_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .seg_val  (seg_val),
    .seg_ctrl (seg_ctrl),
    .seg_an   (seg_an),
    .seg_cath (seg_cath)
  );

endmodule

// File: tb/tb_mmio_io_responder.sv
// Directed bench for mmio_io_responder with a fast tick prescaler and short scan slots.
module tb_mmio_io_responder;

  localparam logic [31:0] BASE = 32'hFFFFF800;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        io_read = 1'b0;
  logic        io_write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic [15:0] switches = '0;
  logic [4:0]  keys = '0;
  logic [15:0] leds;
  logic [7:0]  seg_an;
  logic [7:0]  seg_cath;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mmio_io_responder #(
    .CLK_HZ      (10_000),
    .SCAN_DIV    (4),
    .DEBOUNCE_MS (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .io_read     (io_read),
    .io_write    (io_write),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .switches    (switches),
    .keys        (keys),
    .leds        (leds),
    .seg_an      (seg_an),
    .seg_cath    (seg_cath)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic io_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    io_write = 1'b1;
    addr = a;
    wdata = d;
    @(negedge clk);
    io_write = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    io_read = 1'b1;
    addr = a;
    @(negedge clk);
    io_read = 1'b0;
    check("valid_pulse_hi", {31'd0, rdata_valid}, 32'd1);
    d = rdata;
    @(negedge clk);
    check("valid_pulse_lo", {31'd0, rdata_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int fe_cnt;
    int i;

    repeat (3) @(negedge clk);
    check("rst_rdata", rdata, 32'h0);
    check("rst_valid", {31'd0, rdata_valid}, 32'd0);
    check("rst_leds", {16'd0, leds}, 32'h0);
    check("rst_seg_an", {24'd0, seg_an}, 32'hFF);
    check("rst_seg_cath", {24'd0, seg_cath}, 32'hFF);
    rst_n = 1'b1;

    // 10-cycle ms tick: read sampled on the 31st edge sees three ticks
    repeat (29) @(negedge clk);
    do_read(BASE + 32'h10, d);
    check("tick_30cyc", d, 32'd3);

    do_read(BASE + 32'h14, d);
    check("segctl_reset", d, 32'h1FF);
    do_read(BASE + 32'h0C, d);
    check("segval_reset", d, 32'h0);

    io_wr(BASE + 32'h00, 32'h0000A5A5);
    check("led_after_write", {16'd0, leds}, 32'hA5A5);
    do_read(BASE + 32'h00, d);
    check("led_readback", d, 32'h0000A5A5);

    io_wr(BASE + 32'h04, 32'hFFFFFFFF);
    io_wr(BASE + 32'h3C, 32'h00005A5A);
    switches = 16'h1234;
    repeat (3) @(negedge clk);
    do_read(BASE + 32'h04, d);
    check("sw_read", d, 32'h00001234);
    do_read(BASE + 32'h3C, d);
    check("unmapped_read", d, 32'h0);
    do_read(BASE + 32'h00, d);
    check("led_unchanged", d, 32'h0000A5A5);

    @(negedge clk);
    io_read = 1'b1;
    io_write = 1'b1;
    addr = BASE;
    wdata = 32'h00001111;
    @(negedge clk);
    io_read = 1'b0;
    io_write = 1'b0;
    check("rw_valid", {31'd0, rdata_valid}, 32'd1);
    check("rw_pre_write", rdata, 32'h0000A5A5);
    check("rw_led_new", {16'd0, leds}, 32'h1111);

    @(negedge clk);
    keys[2] = 1'b1;
    repeat (5) @(negedge clk);
    keys[2] = 1'b0;
    repeat (4) @(negedge clk);
    do_read(BASE + 32'h08, d);
    check("key2_first", d, 32'h4);
    do_read(BASE + 32'h08, d);
    check("key2_cleared", d, 32'h0);

    @(negedge clk);
    keys[0] = 1'b1;
    @(negedge clk);
    do_read(BASE + 32'h08, d);
    check("key0_race_read", d, 32'h0);
    do_read(BASE + 32'h08, d);
    check("key0_kept", d, 32'h1);
    keys[0] = 1'b0;

    for (i = 0; i < 20 && dut.presc != 32'd2; i++) @(negedge clk);
    check("tick_phase_sync", dut.presc, 32'd2);
    force dut.tick_cnt = 32'hFFFFFFFF;
    @(negedge clk);
    release dut.tick_cnt;
    repeat (8) @(negedge clk);
    do_read(BASE + 32'h10, d);
    check("tick_wrap", d, 32'h0);

    io_wr(BASE + 32'h0C, 32'h0000000F);
    io_wr(BASE + 32'h14, 32'h00000101);
    do_read(BASE + 32'h0C, d);
    check("segval_readback", d, 32'h0000000F);
    do_read(BASE + 32'h14, d);
    check("segctl_readback", d, 32'h101);
    repeat (3) @(negedge clk);
    fe_cnt = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (seg_an == 8'hFE) fe_cnt++;
      check("seg_slot", {16'd0, seg_an, seg_cath},
            (seg_an == 8'hFE) ? 32'h0000FE8E : 32'h0000FFC0);
    end
    check("seg_digit0_slots", fe_cnt, 8);

    @(negedge clk);
    io_write = 1'b1;
    io_read = 1'b1;
    addr = BASE;
    wdata = 32'h0000FFFF;
    rst_n = 1'b0;
    @(negedge clk);
    io_write = 1'b0;
    io_read = 1'b0;
    check("abort_leds", {16'd0, leds}, 32'h0);
    check("abort_valid", {31'd0, rdata_valid}, 32'd0);
    check("abort_rdata", rdata, 32'h0);
    check("abort_seg_an", {24'd0, seg_an}, 32'hFF);
    check("abort_seg_cath", {24'd0, seg_cath}, 32'hFF);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_abort_valid", {31'd0, rdata_valid}, 32'd0);
    check("post_abort_leds", {16'd0, leds}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
